// File: rtl/mac_lanes_window.sv
// Multi-lane fixed-point multiply-accumulate with optional windowed output.
// Each accepted beat adds the sum of lanes_p signed a*b products into a signed
// accumulator. A result leaves through a registered valid/ready port, either
// every beat (window_p == 0) or once every window_p beats. Overflow wraps or
// saturates, and a sticky flag marks every result whose window overflowed.
module mac_lanes_window #(
  parameter int int_in_p   = 8,
  parameter int frac_in_p  = 8,
  parameter int int_out_p  = 16,
  parameter int frac_out_p = 16,
  parameter int lanes_p    = 2,
  parameter int window_p   = 4,
  parameter int saturate_p = 1
) (
  input  logic                                           clk_i,
  input  logic                                           reset_ni,
  input  logic [lanes_p*(int_in_p+frac_in_p)-1:0]        a_i,
  input  logic [lanes_p*(int_in_p+frac_in_p)-1:0]        b_i,
  input  logic                                           clear_i,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  output logic                                           valid_o,
  output logic [int_out_p+frac_out_p-1:0]                data_o,
  output logic                                           sat_o,
  input  logic                                           ready_i
);

  localparam int W_IN   = int_in_p + frac_in_p;
  localparam int W_OUT  = int_out_p + frac_out_p;
  localparam int W_PROD = 2 * W_IN;
  // One guard bit for the accumulator add plus headroom for the lane sum.
  localparam int W_SUM  = W_OUT + $clog2(lanes_p) + 1;
  // A running accumulator never counts beats; keep a 1-bit counter so the
  // declaration stays legal.
  localparam int CNT_W  = (window_p > 0) ? $clog2(window_p + 1) : 1;
  localparam int LAST_I = (window_p > 0) ? window_p - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = LAST_I[CNT_W-1:0];

  localparam logic signed [W_OUT-1:0] MAX_V = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_OUT-1:0] MIN_V = {1'b1, {(W_OUT-1){1'b0}}};

  logic signed [W_OUT-1:0]  acc;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     ovf_flag;

  logic signed [W_IN-1:0]   a_lane;
  logic signed [W_IN-1:0]   b_lane;
  logic signed [W_PROD-1:0] p_lane;
  logic signed [W_SUM-1:0]  prod_sum;
  logic signed [W_OUT-1:0]  base;
  logic signed [W_SUM-1:0]  sum_full;
  logic [W_SUM-W_OUT:0]     sum_top;
  logic                     new_ovf;
  logic signed [W_OUT-1:0]  acc_nx;
  logic [CNT_W-1:0]         cnt_eff;
  logic                     flag_eff;
  logic                     emit_beat;
  logic                     accept;

  // Sum of sign-extended lane products for the current beat.
  always_comb begin
    prod_sum = '0;
    a_lane   = '0;
    b_lane   = '0;
    p_lane   = '0;
    for (int k = 0; k < lanes_p; k++) begin
      a_lane   = a_i[k*W_IN +: W_IN];
      b_lane   = b_i[k*W_IN +: W_IN];
      p_lane   = a_lane * b_lane;
      prod_sum = prod_sum + W_SUM'(p_lane);
    end
  end

  // Accumulate at full width, detect overflow of the output range and clip.
  always_comb begin
    base     = clear_i ? '0 : acc;
    sum_full = W_SUM'(base) + prod_sum;
    // In range exactly when every bit from the output sign bit upward agrees.
    sum_top  = sum_full[W_SUM-1:W_OUT-1];
    new_ovf  = (|sum_top) & ~(&sum_top);
    acc_nx   = sum_full[W_OUT-1:0];
    if (new_ovf && (saturate_p != 0)) begin
      acc_nx = sum_full[W_SUM-1] ? MIN_V : MAX_V;
    end
  end

  // A clear arriving with a beat makes that beat the first of a fresh window,
  // so both the window position and the sticky flag are taken as zero.
  always_comb begin
    cnt_eff   = clear_i ? '0 : beat_cnt;
    flag_eff  = clear_i ? 1'b0 : ovf_flag;
    emit_beat = (window_p == 0) ? 1'b1 : (cnt_eff == LAST_CNT);
    ready_o   = !valid_o || ready_i || !emit_beat;
    accept    = valid_i && ready_o;
  end

  // Accumulator, window position and sticky overflow flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc      <= '0;
      beat_cnt <= '0;
      ovf_flag <= 1'b0;
    end else if (accept) begin
      if (emit_beat) begin
        acc      <= (window_p == 0) ? acc_nx : '0;
        beat_cnt <= '0;
        ovf_flag <= 1'b0;
      end else begin
        acc      <= acc_nx;
        beat_cnt <= cnt_eff + CNT_W'(1);
        ovf_flag <= flag_eff | new_ovf;
      end
    end else if (clear_i) begin
      acc      <= '0;
      beat_cnt <= '0;
      ovf_flag <= 1'b0;
    end
  end

  // Registered result port; data_o keeps its last value once consumed.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sat_o   <= 1'b0;
    end else if (accept && emit_beat) begin
      valid_o <= 1'b1;
      data_o  <= acc_nx;
      sat_o   <= flag_eff | new_ovf;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_lanes_window.sv
// Bench for mac_lanes_window: four instances (windowed saturating, windowed
// wrapping, running, single-beat window) share one stimulus stream and are
// checked every cycle against an arithmetic reference, plus fixed vectors.
module tb_mac_lanes_window;

  localparam int NC = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [31:0]   a_i, b_i;
  logic          clear_i, valid_i, ready_i;
  logic [NC-1:0] rdy_o, vld_o, st_o;
  logic [31:0]   dat_o [NC];

  int n_checks = 0;
  int n_fail   = 0;

  int cfg_win [NC] = '{4, 4, 0, 1};
  bit cfg_sat [NC] = '{1, 0, 1, 1};

  longint      m_acc  [NC];
  int          m_cnt  [NC];
  bit          m_flag [NC];
  bit          m_vo   [NC];
  bit          m_so   [NC];
  logic [31:0] m_do   [NC];

  always #10 clk_i = ~clk_i;

  mac_lanes_window #(.window_p(4), .saturate_p(1)) u_win (
    .clk_i(clk_i), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(rdy_o[0]), .valid_o(vld_o[0]), .data_o(dat_o[0]),
    .sat_o(st_o[0]), .ready_i(ready_i));
  mac_lanes_window #(.window_p(4), .saturate_p(0)) u_wrap (
    .clk_i(clk_i), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(rdy_o[1]), .valid_o(vld_o[1]), .data_o(dat_o[1]),
    .sat_o(st_o[1]), .ready_i(ready_i));
  mac_lanes_window #(.window_p(0), .saturate_p(1)) u_run (
    .clk_i(clk_i), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(rdy_o[2]), .valid_o(vld_o[2]), .data_o(dat_o[2]),
    .sat_o(st_o[2]), .ready_i(ready_i));
  mac_lanes_window #(.window_p(1), .saturate_p(1)) u_one (
    .clk_i(clk_i), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(rdy_o[3]), .valid_o(vld_o[3]), .data_o(dat_o[3]),
    .sat_o(st_o[3]), .ready_i(ready_i));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Exact real-valued beat sum in Q16.16 units.
  function automatic longint beat_sum();
    logic signed [15:0] sa, sb;
    longint p = 0;
    for (int k = 0; k < 2; k++) begin
      sa = a_i[k*16 +: 16];
      sb = b_i[k*16 +: 16];
      p += longint'(sa) * longint'(sb);
    end
    return p;
  endfunction

  function automatic bit m_emit(input int c);
    int pos = clear_i ? 0 : m_cnt[c];
    return (cfg_win[c] == 0) || (pos == cfg_win[c] - 1);
  endfunction

  function automatic bit m_ready(input int c);
    return !m_vo[c] || ready_i || !m_emit(c);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_acc[c] = 0; m_cnt[c] = 0; m_flag[c] = 0;
      m_vo[c] = 0; m_so[c] = 0; m_do[c] = '0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit emit = m_emit(c);
      bit acc_ok = valid_i && m_ready(c);
      bit drop = m_vo[c] && ready_i;
      if (acc_ok) begin
        longint s = (clear_i ? 0 : m_acc[c]) + beat_sum();
        bit ovf = (s > MAXV) || (s < MINV);
        bit fl = (clear_i ? 1'b0 : m_flag[c]) | ovf;
        longint r = s;
        if (ovf) r = cfg_sat[c] ? ((s > MAXV) ? MAXV : MINV) : longint'(int'(s));
        if (emit) begin
          m_vo[c] = 1; m_do[c] = r[31:0]; m_so[c] = fl;
          m_acc[c] = (cfg_win[c] == 0) ? r : 0;
          m_cnt[c] = 0; m_flag[c] = 0;
        end else begin
          if (drop) m_vo[c] = 0;
          m_acc[c] = r;
          m_cnt[c] = (clear_i ? 0 : m_cnt[c]) + 1;
          m_flag[c] = fl;
        end
      end else begin
        if (drop) m_vo[c] = 0;
        if (clear_i) begin
          m_acc[c] = 0; m_cnt[c] = 0; m_flag[c] = 0;
        end
      end
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic tick();
    #2;
    for (int c = 0; c < NC; c++) chk($sformatf("ready_o[%0d]", c), rdy_o[c], m_ready(c));
    @(posedge clk_i);
    model_step();
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("valid_o[%0d]", c), vld_o[c], m_vo[c]);
      chk($sformatf("data_o[%0d]", c), dat_o[c], m_do[c]);
      chk($sformatf("sat_o[%0d]", c), st_o[c], m_so[c]);
    end
  endtask

  task automatic beat(input logic [15:0] a0, a1, b0, b1, input bit v, input bit clr);
    a_i = {a1, a0};
    b_i = {b1, b0};
    valid_i = v;
    clear_i = clr;
    tick();
  endtask

  typedef struct {
    logic [15:0] a0, a1, b0, b1;
    logic [31:0] sat_d;
    bit          sat_f;
    logic [31:0] wrap_d;
    bit          wrap_f;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h0100, 16'h0100, 16'h0080, 16'h0040, 32'h0003_0000, 1'b0, 32'h0003_0000, 1'b0};
    vt[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF, 1'b1, 32'hFFF8_0008, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 32'h8000_0000, 1'b1, 32'h0004_0000, 1'b1};
    vt[4] = '{16'h0180, 16'h0000, 16'hFF00, 16'h1234, 32'hFFFA_0000, 1'b0, 32'hFFFA_0000, 1'b0};
    vt[5] = '{16'h0100, 16'h0100, 16'h0200, 16'h0200, 32'h0010_0000, 1'b0, 32'h0010_0000, 1'b0};

    reset_ni = 1'b0;
    a_i = '0; b_i = '0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #5 reset_ni = 1'b1;
    #2;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("reset valid_o[%0d]", c), vld_o[c], 0);
      chk($sformatf("reset data_o[%0d]", c), dat_o[c], 0);
      chk($sformatf("reset sat_o[%0d]", c), st_o[c], 0);
      chk($sformatf("reset ready_o[%0d]", c), rdy_o[c], 1);
    end

    // Fixed windows: one result per four beats, each window starts from zero.
    beat(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      repeat (4) beat(vt[i].a0, vt[i].a1, vt[i].b0, vt[i].b1, 1, 0);
      chk($sformatf("vec%0d valid", i), vld_o[0], 1);
      chk($sformatf("vec%0d sat data", i), dat_o[0], vt[i].sat_d);
      chk($sformatf("vec%0d sat flag", i), st_o[0], vt[i].sat_f);
      chk($sformatf("vec%0d wrap data", i), dat_o[1], vt[i].wrap_d);
      chk($sformatf("vec%0d wrap flag", i), st_o[1], vt[i].wrap_f);
    end

    // Backpressure: next window fills, its last beat stalls until ready_i.
    beat(0, 0, 0, 0, 0, 0);
    ready_i = 1'b0;
    repeat (4) beat(16'h0100, 16'h0100, 16'h0080, 16'h0040, 1, 0);
    chk("stall first result valid", vld_o[0], 1);
    for (int i = 0; i < 3; i++) begin
      a_i = {16'h0100, 16'h0100}; b_i = {16'h0200, 16'h0200}; valid_i = 1'b1;
      #1 chk($sformatf("stall beat%0d ready", i + 1), rdy_o[0], 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall beat4 ready", rdy_o[0], 0);
      tick();
      chk("stall data held", dat_o[0], 32'h0003_0000);
      chk("stall valid held", vld_o[0], 1);
    end
    ready_i = 1'b1;
    tick();
    chk("stall released data", dat_o[0], 32'h0010_0000);
    chk("stall released valid", vld_o[0], 1);

    // Clear between beats discards the partial window.
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 0);
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 0);
    beat(0, 0, 0, 0, 0, 1);
    repeat (4) beat(16'h0100, 16'h0100, 16'h0200, 16'h0200, 1, 0);
    chk("clear window data", dat_o[0], 32'h0010_0000);
    chk("clear window sat", st_o[0], 0);

    // Running mode keeps accumulating; single-beat window emits each beat.
    for (int i = 0; i < 8; i++) begin
      beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, (i == 0));
      chk($sformatf("running beat%0d", i + 1), dat_o[2], 32'h0002_0000 * (i + 1));
      chk($sformatf("window1 beat%0d", i + 1), dat_o[3], 32'h0002_0000);
      chk($sformatf("window1 valid%0d", i + 1), vld_o[3], 1);
    end

    // Asynchronous reset mid-window with a result pending.
    beat(0, 0, 0, 0, 0, 1);
    ready_i = 1'b0;
    repeat (4) beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 0);
    repeat (2) beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 0);
    chk("pre-reset valid", vld_o[0], 1);
    valid_i = 1'b0;
    #3 reset_ni = 1'b0;
    #1;
    model_reset();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("async reset valid_o[%0d]", c), vld_o[c], 0);
      chk($sformatf("async reset data_o[%0d]", c), dat_o[c], 0);
    end
    #5 reset_ni = 1'b1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (4) beat(16'h0100, 16'h0100, 16'h0080, 16'h0040, 1, 0);
    chk("post-reset data", dat_o[0], 32'h0003_0000);
    chk("post-reset sat", st_o[0], 0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] l [4];
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 5))
          0: l[k] = 16'h7FFF;
          1: l[k] = 16'h8000;
          default: l[k] = 16'($urandom);
        endcase
      end
      ready_i = ($urandom_range(0, 3) != 0);
      beat(l[0], l[1], l[2], l[3], ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
